frame_arbiter: RTL

- N-channel successor to the fixed two-interface (jawny/tajny) wiring; sits between N Interface instances and the Core.
- Buffers one decoded frame per channel and grants the Core to channels round-robin, one frame at a time.
- Waits for the Core's confirmation, retransmits on ERROR or timeout, and routes the final confirmation back to the originating channel.
- Per-channel busy outputs replace the hard-wired semafor cross-coupling.

---
 rtl/frame_pkg.sv | 39 +++
 rtl/rr_arbiter.sv | 35 +++
 rtl/frame_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/frame_pkg.sv
// Shared frame-format constants, confirmation codes and arbiter state type used
// between the channel interfaces, the frame arbiter and the Core.
package frame_pkg;

    localparam int PREAMBLE_BYTES = 1;
    localparam int DATA_BYTES     = 64;
    localparam int CRC_BYTES      = 2;
    localparam int NONCE_BYTES    = 16;
    localparam int FRAME_BITS_DEF = (PREAMBLE_BYTES + DATA_BYTES + CRC_BYTES + NONCE_BYTES) * 8;

    // Frame-type markers carried in the preamble byte
    localparam logic [7:0] FIRST_FRAME = 8'h01;
    localparam logic [7:0] LAST_FRAME  = 8'h02;
    localparam logic [7:0] NORMALNA    = 8'h03;
    localparam logic [7:0] POJEDYNCZA  = 8'h00;

    // Line framing and byte stuffing
    localparam logic [7:0] FRAME_START = 8'hC0;
    localparam logic [7:0] FRAME_END   = 8'hC1;
    localparam logic [7:0] ESC_VAL     = 8'h7D;
    localparam logic [7:0] ESC_XOR     = 8'h20;

    // Core confirmation codes
    localparam logic [7:0] OKAY        = 8'h05;
    localparam logic [7:0] ERROR       = 8'h04;
    localparam logic [7:0] FATAL_ERROR = 8'h08;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_CONF = 2'd2
    } arb_state_e;

    // Counter width that stays at least one bit for degenerate sizes
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: the first requesting channel strictly after ptr_i, searched
// circularly; purely combinational.
module rr_arbiter
    import frame_pkg::*;
#(
    parameter  int N_CH = 2,
    localparam int CW   = clog2_min1(N_CH)
) (
    input  logic [N_CH-1:0] req_i,
    input  logic [CW-1:0]   ptr_i,
    output logic [N_CH-1:0] grant_o,
    output logic [CW-1:0]   idx_o,
    output logic            any_o
);

    int cand;

    // Walk from the farthest candidate to the nearest so the nearest one wins
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = 0;
        for (int k = N_CH; k >= 1; k--) begin
            cand = (int'(ptr_i) + k) % N_CH;
            if (req_i[cand]) begin
                grant_o       = '0;
                grant_o[cand] = 1'b1;
                idx_o         = CW'(cand);
                any_o         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_arbiter.sv
// N-channel frame arbiter: one frame buffer per channel, round-robin access to the
// Core, retransmission on error/timeout and routing of the final confirmation.
module frame_arbiter
    import frame_pkg::*;
#(
    parameter  int N_CH        = 2,
    parameter  int FRAME_BITS  = FRAME_BITS_DEF,
    parameter  int MAX_RETRY   = 3,
    parameter  int TIMEOUT_CYC = 50000,
    localparam int CW          = clog2_min1(N_CH),
    localparam int TW          = clog2_min1(TIMEOUT_CYC),
    localparam int RW          = clog2_min1(MAX_RETRY + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_CH*FRAME_BITS-1:0] in_frame,
    input  logic [N_CH-1:0]            in_valid,
    output logic [N_CH-1:0]            in_busy,
    output logic [N_CH-1:0]            ovf,
    output logic [FRAME_BITS-1:0]      out_frame,
    output logic [CW-1:0]              out_chan,
    output logic                       out_valid,
    input  logic                       out_ready,
    input  logic [7:0]                 conf_code,
    input  logic                       conf_valid,
    output logic [7:0]                 conf_out,
    output logic [N_CH-1:0]            conf_out_valid
);

    arb_state_e            state_q;
    logic [N_CH-1:0]       full_q;
    logic [N_CH-1:0]       ovf_q;
    logic [N_CH-1:0]       just_rel_q;
    logic [N_CH-1:0]       conf_out_valid_q;
    logic [CW-1:0]         ptr_q;
    logic [CW-1:0]         out_chan_q;
    logic [FRAME_BITS-1:0] out_frame_q;
    logic                  out_valid_q;
    logic [7:0]            conf_out_q;
    logic [TW-1:0]         timer_q;
    logic [RW-1:0]         retry_q;

    logic [N_CH-1:0]       full_d;
    logic [N_CH-1:0]       capture_vec;
    logic [N_CH-1:0]       drop_vec;
    logic [N_CH-1:0]       release_vec;
    logic [N_CH-1:0]       req_vec;
    logic [N_CH-1:0]       grant_vec;
    logic [CW-1:0]         grant_idx;
    logic                  grant_any;
    logic [FRAME_BITS-1:0] buf_word [N_CH];
    logic [FRAME_BITS-1:0] sel_frame;

    logic                  in_wait;
    logic                  conf_ok;
    logic                  conf_fatal;
    logic                  attempt_fail;
    logic                  retry_left;
    logic                  finish;
    logic [7:0]            finish_code;

    // Outcome of the current WAIT_CONF cycle; a strobed code always beats the timeout
    always_comb begin
        in_wait      = (state_q == WAIT_CONF);
        conf_ok      = in_wait && conf_valid && (conf_code == OKAY);
        conf_fatal   = in_wait && conf_valid && (conf_code == FATAL_ERROR);
        attempt_fail = in_wait && (conf_valid ? ((conf_code != OKAY) && (conf_code != FATAL_ERROR))
                                              : (timer_q == TW'(TIMEOUT_CYC - 1)));
        retry_left   = (retry_q < RW'(MAX_RETRY));
        finish       = conf_ok || conf_fatal || (attempt_fail && !retry_left);
        finish_code  = conf_ok ? OKAY : FATAL_ERROR;
        release_vec  = finish ? (N_CH'(1) << out_chan_q) : '0;
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
        logic [FRAME_BITS-1:0] data_q;

        // A buffer being released this cycle may take a new frame immediately
        assign capture_vec[gi] = in_valid[gi] && (!full_q[gi] || release_vec[gi]);
        assign drop_vec[gi]    = in_valid[gi] && full_q[gi] && !release_vec[gi];
        assign full_d[gi]      = capture_vec[gi] || (full_q[gi] && !release_vec[gi]);

        always_ff @(posedge clk) begin
            if (capture_vec[gi]) begin
                data_q <= in_frame[gi*FRAME_BITS +: FRAME_BITS];
            end
        end

        assign buf_word[gi] = data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q     <= '0;
            ovf_q      <= '0;
            just_rel_q <= '0;
        end else begin
            full_q     <= full_d;
            ovf_q      <= drop_vec;
            just_rel_q <= release_vec;
        end
    end

    // A frame recaptured on its release cycle sits out one arbitration round
    assign req_vec = full_q & ~just_rel_q;

    rr_arbiter #(
        .N_CH (N_CH)
    ) u_rr (
        .req_i   (req_vec),
        .ptr_i   (ptr_q),
        .grant_o (grant_vec),
        .idx_o   (grant_idx),
        .any_o   (grant_any)
    );

    always_comb begin
        sel_frame = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (grant_vec[c]) begin
                sel_frame = sel_frame | buf_word[c];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            ptr_q            <= CW'(N_CH - 1);
            out_valid_q      <= 1'b0;
            out_frame_q      <= '0;
            out_chan_q       <= '0;
            conf_out_q       <= '0;
            conf_out_valid_q <= '0;
            timer_q          <= '0;
            retry_q          <= '0;
        end else begin
            conf_out_valid_q <= '0;
            case (state_q)
                IDLE: begin
                    if (grant_any) begin
                        ptr_q       <= grant_idx;
                        out_chan_q  <= grant_idx;
                        out_frame_q <= sel_frame;
                        retry_q     <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        timer_q     <= '0;
                        state_q     <= WAIT_CONF;
                    end
                end
                WAIT_CONF: begin
                    if (timer_q != '1) begin
                        timer_q <= timer_q + 1'b1;
                    end
                    if (finish) begin
                        conf_out_q       <= finish_code;
                        conf_out_valid_q <= N_CH'(1) << out_chan_q;
                        state_q          <= IDLE;
                    end else if (attempt_fail) begin
                        retry_q     <= retry_q + 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_busy        = full_q;
    assign ovf            = ovf_q;
    assign out_frame      = out_frame_q;
    assign out_chan       = out_chan_q;
    assign out_valid      = out_valid_q;
    assign conf_out       = conf_out_q;
    assign conf_out_valid = conf_out_valid_q;

endmodule
